// File: rtl/time_setter.sv
// Purpose: button-driven BCD time editor that loads a clock's time or alarm register.
// Latency: raw button to FSM action is DB_CYCLES+1 clocks; load strobe lasts LOAD_CYCLES clocks.
// Backpressure: none; pulses arriving during COMMIT are dropped, outputs hold until next edit.
//
// Ports:
//   clk, reset                      - sole clock, synchronous active-high reset
//   btn_mode, btn_inc, btn_enter    - raw (bouncy) push buttons
//   sel_alarm                       - commit target: 0 = clock time, 1 = alarm time
//   cur_H1, cur_H0, cur_M1, cur_M0  - current BCD time from the clock
//   H_in1, H_in0, M_in1, M_in0      - edited BCD value toward the clock's load inputs
//   LD_time, LD_alarm               - registered load strobes
//   edit_field                      - 00 idle, 01 hours, 10 minutes, 11 committing

module time_setter #(
    parameter int DB_CYCLES   = 4,
    parameter int LOAD_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_enter,
    input  logic       sel_alarm,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [2:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [2:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_field
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EDIT_HR  = 2'b01,
        EDIT_MIN = 2'b10,
        COMMIT   = 2'b11
    } state_t;

    state_t          state;
    logic [LW-1:0]   load_cnt;

    // ------------------------------------------------------------------
    // Debounce: bit 0 = mode, bit 1 = inc, bit 2 = enter.
    // The counter runs only while the raw input disagrees with the
    // debounced level; any agreeing sample clears it, so a glitch shorter
    // than DB_CYCLES leaves no trace. The rising-edge pulse is produced on
    // the same edge the level flips, so it is exactly one cycle wide and
    // cannot repeat while the button stays held.
    // ------------------------------------------------------------------
    logic [2:0]    btn_raw;
    logic [2:0]    db_level;
    logic [2:0]    btn_p;
    logic [DW-1:0] db_cnt [3];

    assign btn_raw = {btn_enter, btn_inc, btn_mode};

    always_ff @(posedge clk) begin
        if (reset) begin
            db_level <= '0;
            btn_p    <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                btn_p[i] <= 1'b0;
                if (btn_raw[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_level[i] <= btn_raw[i];
                    db_cnt[i]   <= '0;
                    btn_p[i]    <= btn_raw[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic mode_p;
    logic inc_p;
    logic enter_p;

    assign mode_p  = btn_p[0];
    assign inc_p   = btn_p[1];
    assign enter_p = btn_p[2];

    // ------------------------------------------------------------------
    // BCD increment helpers. Results are {tens, units}.
    // ------------------------------------------------------------------
    function automatic logic [5:0] hr_inc(input logic [1:0] h1, input logic [3:0] h0);
        logic [5:0] r;
        if (h1 == 2'd2 && h0 == 4'd3) begin
            r = 6'd0;
        end else if (h0 == 4'd9) begin
            r = {h1 + 2'd1, 4'd0};
        end else begin
            r = {h1, h0 + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] min_inc(input logic [2:0] m1, input logic [3:0] m0);
        logic [6:0] r;
        if (m1 == 3'd5 && m0 == 4'd9) begin
            r = 7'd0;
        end else if (m0 == 4'd9) begin
            r = {m1 + 3'd1, 4'd0};
        end else begin
            r = {m1, m0 + 4'd1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Edit / commit FSM. The strobes double as the latched target select:
    // they are set from sel_alarm on the entry edge and only cleared on
    // exit or reset, so sel_alarm is ignored for the rest of COMMIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            H_in1    <= '0;
            H_in0    <= '0;
            M_in1    <= '0;
            M_in0    <= '0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            load_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode_p) begin
                        H_in1 <= cur_H1;
                        H_in0 <= cur_H0;
                        M_in1 <= cur_M1;
                        M_in0 <= cur_M0;
                        state <= EDIT_HR;
                    end
                end

                EDIT_HR, EDIT_MIN: begin
                    // Increment acts on the field selected before this edge,
                    // even when a field change or commit happens on it too.
                    if (inc_p) begin
                        if (state == EDIT_HR) begin
                            {H_in1, H_in0} <= hr_inc(H_in1, H_in0);
                        end else begin
                            {M_in1, M_in0} <= min_inc(M_in1, M_in0);
                        end
                    end
                    // Enter takes priority over a simultaneous mode press.
                    if (enter_p) begin
                        state    <= COMMIT;
                        LD_time  <= ~sel_alarm;
                        LD_alarm <= sel_alarm;
                        load_cnt <= '0;
                    end else if (mode_p) begin
                        state <= (state == EDIT_HR) ? EDIT_MIN : EDIT_HR;
                    end
                end

                COMMIT: begin
                    if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
                        state    <= IDLE;
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                        load_cnt <= '0;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign edit_field = state;

endmodule

// File: tb/tb_time_setter.sv
// Purpose: directed self-checking bench for time_setter.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable.

module tb_time_setter;

    logic       clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_enter;
    logic       sel_alarm;
    logic [1:0] cur_H1;
    logic [3:0] cur_H0;
    logic [2:0] cur_M1;
    logic [3:0] cur_M0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic [1:0] edit_field;

    int checks;
    int errors;
    int lt_cnt;
    int la_cnt;
    int both_cnt;

    time_setter #(
        .DB_CYCLES  (4),
        .LOAD_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_enter (btn_enter),
        .sel_alarm (sel_alarm),
        .cur_H1    (cur_H1),
        .cur_H0    (cur_H0),
        .cur_M1    (cur_M1),
        .cur_M0    (cur_M0),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .edit_field(edit_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and tally strobe activity seen after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (LD_time)             lt_cnt++;
        if (LD_alarm)            la_cnt++;
        if (LD_time && LD_alarm) both_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] bcd(input int h, input int m);
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        h1 = 2'(h / 10);
        h0 = 4'(h % 10);
        m1 = 3'(m / 10);
        m0 = 4'(m % 10);
        return {19'd0, h1, h0, m1, m0};
    endfunction

    function automatic logic [31:0] shown();
        return {19'd0, H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic set_cur(input int h, input int m);
        cur_H1 = 2'(h / 10);
        cur_H0 = 4'(h % 10);
        cur_M1 = 3'(m / 10);
        cur_M0 = 4'(m % 10);
    endtask

    // mask bit 0 = mode, 1 = inc, 2 = enter. Hold for n cycles, then
    // release and let the debouncers settle back low.
    task automatic press(input logic [2:0] mask, input int n);
        btn_mode  = mask[0];
        btn_inc   = mask[1];
        btn_enter = mask[2];
        ticks(n);
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_enter = 1'b0;
        ticks(6);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (edit_field == 2'b00) break;
            tick();
        end
        chk(tag, 32'(edit_field), 32'd0);
    endtask

    task automatic clear_counts();
        lt_cnt   = 0;
        la_cnt   = 0;
        both_cnt = 0;
    endtask

    int lt_snap;

    initial begin
        checks    = 0;
        errors    = 0;
        clear_counts();
        reset     = 1'b1;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_enter = 1'b0;
        sel_alarm = 1'b0;
        set_cur(0, 0);
        ticks(2);

        // Reset state
        chk("rst_time",  shown(), bcd(0, 0));
        chk("rst_ld_t",  32'(LD_time), 32'd0);
        chk("rst_ld_a",  32'(LD_alarm), 32'd0);
        chk("rst_field", 32'(edit_field), 32'd0);
        reset = 1'b0;
        ticks(2);

        // Buttons ignored in IDLE except mode
        press(3'b110, 6);
        chk("idle_ignore_field", 32'(edit_field), 32'd0);
        chk("idle_ignore_time",  shown(), bcd(0, 0));

        // 15:39 -> 17:39, commit to time
        set_cur(15, 39);
        press(3'b001, 5);
        chk("s1_field_hr", 32'(edit_field), 32'd1);
        chk("s1_copy",     shown(), bcd(15, 39));
        press(3'b010, 5);
        press(3'b010, 5);
        chk("s1_inc2", shown(), bcd(17, 39));
        sel_alarm = 1'b0;
        clear_counts();
        press(3'b100, 5);
        chk("s1_commit_field", 32'(edit_field), 32'd3);
        wait_idle("s1_idle", 300);
        ticks(5);
        chk("s1_lt_cnt", 32'(lt_cnt), 32'd100);
        chk("s1_la_cnt", 32'(la_cnt), 32'd0);
        chk("s1_hold",   shown(), bcd(17, 39));

        // 23:58 wraps to 00:00, commit to alarm
        set_cur(23, 58);
        press(3'b001, 5);
        press(3'b010, 5);
        chk("s2_hr_wrap", shown(), bcd(0, 58));
        press(3'b001, 5);
        chk("s2_field_min", 32'(edit_field), 32'd2);
        press(3'b010, 5);
        chk("s2_min59", shown(), bcd(0, 59));
        press(3'b010, 5);
        chk("s2_min_wrap", shown(), bcd(0, 0));
        sel_alarm = 1'b1;
        clear_counts();
        press(3'b100, 5);
        wait_idle("s2_idle", 300);
        ticks(5);
        chk("s2_la_cnt", 32'(la_cnt), 32'd100);
        chk("s2_lt_cnt", 32'(lt_cnt), 32'd0);
        chk("s2_both",   32'(both_cnt), 32'd0);

        // Digit carries 09 -> 10 and 19 -> 20; mode returns to hours
        set_cur(9, 19);
        press(3'b001, 5);
        press(3'b010, 5);
        chk("s3_hr_carry", shown(), bcd(10, 19));
        press(3'b001, 5);
        press(3'b010, 5);
        chk("s3_min_carry", shown(), bcd(10, 20));
        press(3'b001, 5);
        chk("s3_back_hr", 32'(edit_field), 32'd1);
        sel_alarm = 1'b0;
        press(3'b100, 5);
        wait_idle("s3_idle", 300);

        // Debounce: 3-cycle glitch ignored, 4-cycle hold counts once, long hold once
        set_cur(12, 0);
        press(3'b001, 5);
        press(3'b010, 3);
        chk("s4_glitch", shown(), bcd(12, 0));
        press(3'b010, 4);
        chk("s4_hold4", shown(), bcd(13, 0));
        press(3'b010, 500);
        chk("s4_hold500", shown(), bcd(14, 0));

        // Mode + enter together -> COMMIT; sel_alarm toggled mid-commit ignored
        sel_alarm = 1'b0;
        clear_counts();
        btn_mode  = 1'b1;
        btn_enter = 1'b1;
        ticks(5);
        chk("s5_field", 32'(edit_field), 32'd3);
        chk("s5_hours", shown(), bcd(14, 0));
        chk("s5_ld_t",  32'(LD_time), 32'd1);
        btn_mode  = 1'b0;
        btn_enter = 1'b0;
        ticks(20);
        sel_alarm = 1'b1;
        ticks(20);
        sel_alarm = 1'b0;
        wait_idle("s5_idle", 300);
        chk("s5_lt_cnt", 32'(lt_cnt), 32'd100);
        chk("s5_la_cnt", 32'(la_cnt), 32'd0);

        // Reset at commit cycle 50
        set_cur(8, 45);
        press(3'b001, 5);
        sel_alarm = 1'b0;
        clear_counts();
        btn_enter = 1'b1;
        ticks(5);
        btn_enter = 1'b0;
        chk("s6_ld_start", 32'(LD_time), 32'd1);
        ticks(49);
        chk("s6_ld_mid", 32'(LD_time), 32'd1);
        reset = 1'b1;
        tick();
        chk("s6_ld_drop", 32'(LD_time), 32'd0);
        chk("s6_field",   32'(edit_field), 32'd0);
        chk("s6_zero",    shown(), bcd(0, 0));
        reset = 1'b0;
        lt_snap = lt_cnt;
        ticks(150);
        chk("s6_no_resume", 32'(lt_cnt), 32'(lt_snap));
        chk("s6_lt_total",  32'(lt_cnt), 32'd50);

        // Button held through reset release: one pulse after 4 stable cycles
        set_cur(6, 30);
        reset    = 1'b1;
        btn_mode = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(4);
        chk("s7_before", 32'(edit_field), 32'd0);
        tick();
        chk("s7_after", 32'(edit_field), 32'd1);
        chk("s7_copy",  shown(), bcd(6, 30));
        ticks(100);
        chk("s7_no_repeat", 32'(edit_field), 32'd1);
        btn_mode = 1'b0;
        ticks(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable samples required before a button's debounced level changes.
REQ-002 Parameter LOAD_CYCLES, default 100: clocks for which LD_time or LD_alarm is held high during commit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_mode  input  1  raw button: enter edit / toggle field.
REQ-006 btn_inc  input  1  raw button: increment selected field.
REQ-007 btn_enter  input  1  raw button: commit edited value.
REQ-008 sel_alarm  input  1  level: 0 = commit to clock time, 1 = commit to alarm time.
REQ-009 cur_H1 input 2, cur_H0 input 4, cur_M1 input 3, cur_M0 input 4  current BCD time from the clock's H_out1/H_out0/M_out1/M_out0.
REQ-010 H_in1 output 2, H_in0 output 4, M_in1 output 3, M_in0 output 4  edited BCD value, driven to the clock's load inputs.
REQ-011 LD_time  output  1  load-time strobe to clock.
REQ-012 LD_alarm  output  1  load-alarm strobe to clock.
REQ-013 edit_field  output  2  00 idle, 01 hours, 10 minutes, 11 committing.

Function
REQ-014 Each button SHALL be debounced independently: debounced level changes only after the raw input differs from it for DB_CYCLES consecutive clocks; any shorter glitch SHALL be discarded and the counter cleared.
REQ-015 Each debounced rising edge SHALL produce exactly one single-cycle internal pulse (mode_p, inc_p, enter_p); holding a button SHALL NOT repeat.
REQ-016 FSM states SHALL be IDLE, EDIT_HR, EDIT_MIN, COMMIT; edit_field encodes them per REQ-013.
REQ-017 IDLE: mode_p -> EDIT_HR and the edit registers SHALL copy cur_H1/cur_H0/cur_M1/cur_M0 on the same edge; inc_p and enter_p ignored.
REQ-018 EDIT_HR: inc_p increments hours BCD; mode_p -> EDIT_MIN; enter_p -> COMMIT.
REQ-019 EDIT_MIN: inc_p increments minutes BCD; mode_p -> EDIT_HR; enter_p -> COMMIT.
REQ-020 Hour increment: 23 -> 00; H_in0 = 9 -> H_in0 = 0, H_in1 + 1; else H_in0 + 1.
REQ-021 Minute increment: 59 -> 00; M_in0 = 9 -> M_in0 = 0, M_in1 + 1; else M_in0 + 1.
REQ-022 Simultaneous inc_p with mode_p: increment applies to the current field, then the field changes, same edge.
REQ-023 Simultaneous enter_p with mode_p: enter wins, no field change; simultaneous inc_p with enter_p: increment applied, then COMMIT.
REQ-024 On entry to COMMIT, sel_alarm SHALL be latched; sel_alarm changes during COMMIT have no effect.
REQ-025 COMMIT: LD_time (latched sel 0) or LD_alarm (latched sel 1) SHALL be high from the first cycle in COMMIT for exactly LOAD_CYCLES cycles, then return to IDLE with both strobes low; never both high.
REQ-026 H_in1..M_in0 SHALL remain stable throughout COMMIT and hold the committed value in IDLE afterward; all button pulses ignored in COMMIT.
REQ-027 LD_time and LD_alarm SHALL be registered outputs with no combinational path from any input.

Reset
REQ-028 Reset SHALL force state IDLE, H_in1..M_in0 = 00:00, LD_time = LD_alarm = 0, edit_field = 00, debounced levels 0, debounce and load counters 0, on the next rising edge.
REQ-029 Reset asserted mid-COMMIT SHALL drop the active strobe at that edge; no strobe resumes after release.
REQ-030 A button held high through reset release SHALL produce one pulse after DB_CYCLES stable cycles.

Verification
REQ-031 cur=15:39, mode pulse, 2 inc, enter, sel_alarm=0 -> H_in=17:39, LD_time high exactly 100 cycles, LD_alarm stays 0, edit_field returns 00.
REQ-032 cur=23:58, mode, inc, mode, inc x2, enter, sel_alarm=1 -> H_in=00:00 (hour wrap 23->00, minute 58->59->00), LD_alarm high 100 cycles.
REQ-033 Hour 09 -> inc -> 10; minute 19 -> inc -> 20 (digit carry).
REQ-034 btn_inc glitch of 3 cycles in EDIT_HR -> no increment; held 4+ cycles -> exactly one increment, 500-cycle hold -> still one.
REQ-035 mode and enter pulses debounced on same edge in EDIT_HR -> COMMIT, edit_field 11, hours unchanged.
REQ-036 Reset at COMMIT cycle 50 -> LD_time low next edge, outputs 00:00, state IDLE; sel_alarm toggled during a separate COMMIT -> strobe unchanged.
